// File: rtl/add_arbiter_pkg.sv
// Shared types and helpers for the round-robin adder-sharing arbiter.
// Struct widths follow the package configuration constants below.
package add_arbiter_pkg;

    function automatic int unsigned calc_id_w(input int unsigned n);
        int unsigned w;
        if (n < 32'd2) begin
            w = 32'd1;
        end else begin
            w = $clog2(n);
        end
        return w;
    endfunction

    localparam int unsigned N_REQ_C = 32'd4;
    localparam int unsigned WIDTH_C = 32'd8;
    localparam int unsigned ID_W_C  = calc_id_w(N_REQ_C);

    typedef struct packed {
        logic [ID_W_C-1:0]  id;
        logic [WIDTH_C-1:0] data;
    } rsp_t;

    typedef struct packed {
        logic              vld;
        logic [ID_W_C-1:0] id;
    } tag_t;

endpackage

// File: rtl/add_arbiter_rr.sv
// Round-robin priority picker: first set request at or after ptr_i, wrapping.
module rr_arbiter #(
    parameter int unsigned N_REQ_p = 32'd4,
    parameter int unsigned ID_W_p  = 32'd2
) (
    input  logic [N_REQ_p-1:0] req_i,
    input  logic               en_i,
    input  logic [ID_W_p-1:0]  ptr_i,
    output logic [N_REQ_p-1:0] gnt_o,
    output logic [ID_W_p-1:0]  gnt_idx_o,
    output logic               any_o
);

    logic              lo_hit_s;
    logic              hi_hit_s;
    logic [ID_W_p-1:0] lo_idx_s;
    logic [ID_W_p-1:0] hi_idx_s;

    // hi_* keeps the lowest request at or above ptr, lo_* the lowest overall (wrap case)
    always_comb begin
        lo_hit_s = 1'b0;
        hi_hit_s = 1'b0;
        lo_idx_s = '0;
        hi_idx_s = '0;
        for (int i = 0; i < int'(N_REQ_p); i++) begin
            lo_idx_s = (!lo_hit_s && req_i[i]) ? ID_W_p'(i) : lo_idx_s;
            lo_hit_s = lo_hit_s | req_i[i];
            hi_idx_s = (!hi_hit_s && req_i[i] && (ID_W_p'(i) >= ptr_i)) ? ID_W_p'(i) : hi_idx_s;
            hi_hit_s = hi_hit_s | (req_i[i] && (ID_W_p'(i) >= ptr_i));
        end
        gnt_idx_o = hi_hit_s ? hi_idx_s : lo_idx_s;
        any_o     = en_i & lo_hit_s;
        gnt_o     = any_o ? ({{(N_REQ_p-1){1'b0}}, 1'b1} << gnt_idx_o) : '0;
    end

endmodule

// File: rtl/add_arbiter.sv
// Shares one fixed-latency adder among N requesters; results return tagged
// with the requester ID through a credit-protected show-ahead FIFO.
module add_arbiter
    import add_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ_p = N_REQ_C,
    parameter int unsigned WIDTH_p = WIDTH_C,
    parameter int unsigned LAT_p   = 32'd1,
    parameter int unsigned DEPTH_p = 32'd4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_REQ_p-1:0]           req_valid,
    output logic [N_REQ_p-1:0]           req_ready,
    input  logic [N_REQ_p*WIDTH_p-1:0]   req_a,
    input  logic [N_REQ_p*WIDTH_p-1:0]   req_b,
    output logic                         add_en,
    output logic [WIDTH_p-1:0]           add_a,
    output logic [WIDTH_p-1:0]           add_b,
    input  logic [WIDTH_p-1:0]           add_out,
    input  logic                         add_valid,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [calc_id_w(N_REQ_p)-1:0] rsp_id,
    output logic [WIDTH_p-1:0]           rsp_data,
    output logic                         busy,
    output logic                         err
);

    localparam int unsigned ID_W  = calc_id_w(N_REQ_p);
    localparam int unsigned PTR_W = calc_id_w(DEPTH_p);
    localparam int unsigned CNT_W = $clog2(DEPTH_p + 32'd1);
    localparam int unsigned INF_W = $clog2(LAT_p + 32'd1);

    logic [ID_W-1:0]    ptr_q, ptr_d;
    tag_t               tag_q [LAT_p];
    tag_t               tag_in_s;
    tag_t               tail_s;
    rsp_t               mem_q [DEPTH_p];
    rsp_t               head_s;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;

    logic [INF_W-1:0]   inflight_s;
    logic               credit_ok_s;
    logic               issue_s;
    logic [N_REQ_p-1:0] gnt_s;
    logic [ID_W-1:0]    gnt_idx_s;
    logic               push_s;
    logic               pop_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (32'(p) == DEPTH_p - 32'd1) ? '0 : p + PTR_W'(1'b1);
    endfunction

    rr_arbiter #(
        .N_REQ_p (N_REQ_p),
        .ID_W_p  (ID_W)
    ) u_rr (
        .req_i     (req_valid),
        .en_i      (credit_ok_s & ~rst),
        .ptr_i     (ptr_q),
        .gnt_o     (gnt_s),
        .gnt_idx_o (gnt_idx_s),
        .any_o     (issue_s)
    );

    // Credits count both FIFO occupancy and results still inside the adder
    always_comb begin
        inflight_s = '0;
        for (int i = 0; i < int'(LAT_p); i++) begin
            inflight_s = inflight_s + INF_W'(tag_q[i].vld);
        end
        credit_ok_s = (32'(cnt_q) + 32'(inflight_s)) < DEPTH_p;
    end

    // AND-OR operand mux; gnt_s is all-zero when nothing issues
    always_comb begin
        add_a = '0;
        add_b = '0;
        for (int i = 0; i < int'(N_REQ_p); i++) begin
            add_a = add_a | (req_a[i*WIDTH_p +: WIDTH_p] & {WIDTH_p{gnt_s[i]}});
            add_b = add_b | (req_b[i*WIDTH_p +: WIDTH_p] & {WIDTH_p{gnt_s[i]}});
        end
    end

    always_comb begin
        tail_s   = tag_q[LAT_p-1];
        tag_in_s = '{vld: issue_s, id: gnt_idx_s};
        head_s   = mem_q[rd_ptr_q];
        push_s   = add_valid & tail_s.vld;
        pop_s    = rsp_valid & rsp_ready;
        ptr_d    = issue_s ? ((32'(gnt_idx_s) == N_REQ_p - 32'd1) ? '0 : gnt_idx_s + ID_W'(1'b1))
                           : ptr_q;
        wr_ptr_d = push_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_s  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        cnt_d    = cnt_q + CNT_W'(push_s) - CNT_W'(pop_s);
        // A result without a tag, or a tag without a result, is a latency mismatch
        err_d    = err_q | (add_valid ^ tail_s.vld);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            for (int i = 0; i < int'(LAT_p); i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            ptr_q    <= ptr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            tag_q[0] <= tag_in_s;
            for (int i = 1; i < int'(LAT_p); i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    // Storage needs no reset: the count gates visibility
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= '{id: tail_s.id, data: add_out};
        end
    end

    assign req_ready = gnt_s;
    assign add_en    = issue_s;
    assign rsp_valid = (cnt_q != '0);
    assign rsp_id    = head_s.id;
    assign rsp_data  = head_s.data;
    assign busy      = (inflight_s != '0) | rsp_valid;
    assign err       = err_q;

endmodule

// File: tb/tb_add_arbiter.sv
// Directed bench for add_arbiter with a behavioural one-cycle adder.
module tb_add_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        add_en;
    logic [7:0]  add_a;
    logic [7:0]  add_b;
    logic [7:0]  add_out;
    logic        add_valid;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_data;
    logic        busy;
    logic        err;

    logic        adder_vld_q;
    logic [7:0]  adder_sum_q;
    logic        inj;

    int checks   = 0;
    int failures = 0;

    localparam logic [3:0] BP_GNT [12] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h0,
                                           4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8};
    localparam int         BP_ID  [9]  = '{0, 0, 1, 2, 3, 0, 1, 2, 3};

    always #5 clk = ~clk;

    // Latency-1 adder model, reset together with the arbiter
    always @(posedge clk) begin
        if (rst) begin
            adder_vld_q <= 1'b0;
            adder_sum_q <= 8'h00;
        end else begin
            adder_vld_q <= add_en;
            adder_sum_q <= add_a + add_b;
        end
    end

    assign add_valid = adder_vld_q | inj;
    assign add_out   = adder_sum_q;

    add_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .add_en    (add_en),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_out   (add_out),
        .add_valid (add_valid),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .err       (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        req_valid = 4'b1111;
        req_a     = 32'h0;
        req_b     = 32'h0;
        rsp_ready = 1'b1;
        inj       = 1'b0;
        #3;
        check("rst_req_ready", req_ready, 4'b0000);
        check("rst_add_en", add_en, 1'b0);

        next_cycle();
        rst       = 1'b0;
        req_valid = 4'b0000;
        #1;
        check("post_rst_rsp_valid", rsp_valid, 1'b0);
        check("post_rst_busy", busy, 1'b0);
        check("post_rst_err", err, 1'b0);
        check("post_rst_req_ready", req_ready, 4'b0000);

        // single request from requester 2
        next_cycle();
        req_valid = 4'b0100;
        req_a     = 32'h0003_0000;
        req_b     = 32'h0005_0000;
        #1;
        check("single_gnt", req_ready, 4'b0100);
        check("single_add_en", add_en, 1'b1);
        check("single_add_a", add_a, 8'h03);
        check("single_add_b", add_b, 8'h05);
        next_cycle();
        req_valid = 4'b0000;
        #1;
        check("single_t1_add_en", add_en, 1'b0);
        check("single_t1_add_a", add_a, 8'h00);
        check("single_t1_rsp_valid", rsp_valid, 1'b0);
        check("single_t1_busy", busy, 1'b1);
        next_cycle();
        check("single_t2_rsp_valid", rsp_valid, 1'b1);
        check("single_t2_rsp_id", rsp_id, 2'd2);
        check("single_t2_rsp_data", rsp_data, 8'h08);
        next_cycle();
        check("single_t3_rsp_valid", rsp_valid, 1'b0);
        check("single_t3_busy", busy, 1'b0);

        // wrap arithmetic; pointer is 3 so requester 1 wins via wrap
        req_valid = 4'b0010;
        req_a     = 32'h0000_FF00;
        req_b     = 32'h0000_0200;
        #1;
        check("wrap_gnt", req_ready, 4'b0010);
        next_cycle();
        req_valid = 4'b0000;
        next_cycle();
        check("wrap_rsp_valid", rsp_valid, 1'b1);
        check("wrap_rsp_id", rsp_id, 2'd1);
        check("wrap_rsp_data", rsp_data, 8'h01);
        next_cycle();
        check("wrap_drained", rsp_valid, 1'b0);

        // reset with one in flight and two queued; pointer is 2
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        req_a     = {8'd3, 8'd2, 8'd1, 8'd0};
        req_b     = {4{8'd10}};
        #1;
        check("mid_gnt0", req_ready, 4'b0100);
        next_cycle();
        #1;
        check("mid_gnt1", req_ready, 4'b1000);
        next_cycle();
        #1;
        check("mid_gnt2", req_ready, 4'b0001);
        next_cycle();
        req_valid = 4'b0000;
        check("mid_busy", busy, 1'b1);
        check("mid_rsp_valid", rsp_valid, 1'b1);
        check("mid_rsp_id", rsp_id, 2'd2);
        check("mid_rsp_data", rsp_data, 8'd12);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        check("mid_rst_rsp_valid", rsp_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_err", err, 1'b0);
        rsp_ready = 1'b1;

        // continuous round robin: first grant after reset is requester 0
        for (int k = 0; k < 10; k++) begin
            if (k > 0) next_cycle();
            req_valid = (k < 8) ? 4'b1111 : 4'b0000;
            #1;
            if (k < 8) begin
                check("rr_gnt", req_ready, 4'b0001 << (k % 4));
                check("rr_add_a", add_a, k % 4);
            end else begin
                check("rr_idle_gnt", req_ready, 4'b0000);
            end
            if (k >= 2) begin
                check("rr_rsp_valid", rsp_valid, 1'b1);
                check("rr_rsp_id", rsp_id, (k - 2) % 4);
                check("rr_rsp_data", rsp_data, 10 + (k - 2) % 4);
            end
        end
        next_cycle();
        check("rr_end_rsp_valid", rsp_valid, 1'b0);
        check("rr_end_busy", busy, 1'b0);

        // backpressure: four accepts, stall, in-order drain, then resume
        for (int b = 0; b < 16; b++) begin
            if (b > 0) next_cycle();
            rsp_ready = (b >= 7);
            req_valid = (b < 12) ? 4'b1111 : 4'b0000;
            #1;
            if (b < 12) begin
                check("bp_gnt", req_ready, BP_GNT[b]);
            end
            if (b >= 6 && b < 15) begin
                check("bp_rsp_valid", rsp_valid, 1'b1);
                check("bp_rsp_id", rsp_id, BP_ID[b-6]);
                check("bp_rsp_data", rsp_data, 10 + BP_ID[b-6]);
            end
            if (b == 15) begin
                check("bp_end_rsp_valid", rsp_valid, 1'b0);
                check("bp_end_busy", busy, 1'b0);
            end
        end

        // stray adder result with no tag in flight
        next_cycle();
        inj = 1'b1;
        #1;
        check("perr_before", err, 1'b0);
        next_cycle();
        inj = 1'b0;
        check("perr_set", err, 1'b1);
        check("perr_no_push", rsp_valid, 1'b0);
        check("perr_busy", busy, 1'b0);
        next_cycle();
        next_cycle();
        next_cycle();
        check("perr_sticky", err, 1'b1);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        check("perr_cleared", err, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
